edge_pattern_gen: RTL and testbench
===================================

# edge_pattern_gen

Programmable edge/pulse-train generator: the stimulus-side counterpart of the positive/negative edge detectors in this design. On a Start command it drives a registered output `Dout` with a pulse train whose high time, low time and pulse count are set per command. It also raises one-cycle `Pos_mark` and `Neg_mark` strobes aligned with every rising and falling edge it produces. It feeds edge-detection logic and benches with deterministic edges and a self-check reference.

## Interface
- CNT_W, 8, width of the high/low length fields and the phase counter
- NUM_W, 8, width of the pulse-count field and the pulse counter
- Clk  in  1  single clock; all state changes on its rising edge
- Rst  in  1  asynchronous, active-high reset
- Start  in  1  command strobe; sampled only in IDLE
- High_len  in  CNT_W  high-phase length in cycles; 0 treated as 1
- Low_len  in  CNT_W  low-phase length in cycles; 0 treated as 1
- Num_pulses  in  NUM_W  pulses to emit; 0 means an empty command
- Abort  in  1  terminates an active train
- Dout  out  1  generated waveform, registered
- Pos_mark  out  1  one-cycle strobe in the first cycle Dout=1 of each pulse
- Neg_mark  out  1  one-cycle strobe in the first cycle Dout=0 after a high phase
- Busy  out  1  high while a train is in progress
- Done  out  1  one-cycle strobe on normal completion

## Operation
- Reset values: Dout=0, Pos_mark=0, Neg_mark=0, Busy=0, Done=0, state=IDLE, counters=0.
- States: IDLE, HIGH, LOW.
- IDLE with Start=1 and Num_pulses≠0:
  - Latch High_len, Low_len and Num_pulses.
  - Next state HIGH, with Dout=1, Pos_mark=1 and Busy=1.
- IDLE with Start=1 and Num_pulses=0: stay IDLE and pulse Done for one cycle. No edges, no marks, Busy stays 0.
- HIGH lasts max(High_len,1) cycles, then goes to LOW with Dout=0 and Neg_mark=1.
- LOW lasts max(Low_len,1) cycles, then:
  - If pulses remain: go to HIGH with Pos_mark=1.
  - Otherwise: go to IDLE with Busy=0 and Done=1.
- Phase counter loads len−1 on entry to a phase and counts down; the phase ends when the counter reads 0. Pulse counter loads Num_pulses on accept and decrements on each HIGH→LOW transition.
- Inputs Start, High_len, Low_len and Num_pulses are ignored while Busy. The latched copy alone governs the train.
- Abort while Busy: on the next edge go to IDLE with Dout=0 and Busy=0, and do not assert Done. If Dout was 1, assert Neg_mark in that cycle so the marks stay consistent with Dout.
- Abort in IDLE has no effect. Abort and Start in the same IDLE cycle: Start wins.
- Rst asserted mid-train forces all outputs to 0 immediately, with no Done and no marks. Operation resumes from IDLE after Rst deasserts.

## Timing
- Accept latency: Start sampled at edge k gives Dout=1 and Pos_mark=1 in cycle k+1 (cycle 0 of the train).
- A train lasts exactly N·(H′+L′) cycles, where H′=max(H,1) and L′=max(L,1). Done follows in the next cycle, and Busy is already 0 in that cycle.
- The Done cycle is IDLE, so a Start in that cycle is accepted. The back-to-back gap is exactly one Dout=0 cycle beyond L′.
- Marks are single-cycle and never both high in the same cycle. Pos_mark=1 implies Dout=1 with Dout=0 in the prior cycle; Neg_mark=1 implies the inverse.
- All outputs come directly from flops, with no combinational path from inputs to outputs.

## Structure
- Shared package edge_pkg holds:
  - State enum (IDLE, HIGH, LOW).
  - Default CNT_W and NUM_W constants.
- One natural sub-module, edge_dcount: a loadable down-counter with parameterized width, a zero flag and a load/enable input. Instantiate it twice, once for phase and once for pulses.
- Top level holds the FSM and the output registers.

## Test plan
- H=2, L=3, N=2: Dout over cycles 0–9 = 1,1,0,0,0,1,1,0,0,0. Pos_mark at 0 and 5, Neg_mark at 2 and 7, Busy high in 0–9, Done at cycle 10.
- H=0, L=0, N=3: Dout = 1,0,1,0,1,0. Marks every cycle, alternating. Done at cycle 6.
- N=0: Done one cycle after accept. Dout, marks and Busy stay 0 throughout.
- H=4, L=2, N=1, Abort during cycle 1: Dout=0 and Neg_mark=1 in cycle 2, Busy=0, no Done. A Start in cycle 2 is accepted, with Dout=1 in cycle 3.
- H=1, L=1, N=1, Start held high with fields changed mid-train: Dout = 1,0,0(Done),1,0,0(Done)… Mid-train field changes have no effect.
- Rst asserted asynchronously in the middle of a LOW phase: all outputs 0 without waiting for a clock edge, no Done. After release, a normal train runs correctly.
- All scenarios: bench edge-detector model on Dout matches Pos_mark and Neg_mark cycle-for-cycle.

Source files
------------

// File: rtl/edge_pkg.sv
// edge_pkg: shared state encoding and default widths for the edge pattern generator.
package edge_pkg;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_NUM_W = 8;
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
endpackage

// File: rtl/edge_dcount.sv
// edge_dcount: loadable down-counter with a zero flag.
module edge_dcount #(parameter int W = 8) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic         zero
);
   logic [W-1:0] q;
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) q <= '0;
      else if (load) q <= d;
      else if (en) q <= q - W'(1);
   assign zero = (q == '0);
endmodule

// File: rtl/edge_pattern_gen.sv
// edge_pattern_gen: programmable pulse-train generator with edge-aligned mark strobes.
module edge_pattern_gen import edge_pkg::*; #(
   parameter int CNT_W = DEF_CNT_W,
   parameter int NUM_W = DEF_NUM_W
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [CNT_W-1:0] High_len,
   input  logic [CNT_W-1:0] Low_len,
   input  logic [NUM_W-1:0] Num_pulses,
   input  logic             Abort,
   output logic             Dout,
   output logic             Pos_mark,
   output logic             Neg_mark,
   output logic             Busy,
   output logic             Done
);
   state_t state, state_n;
   logic [CNT_W-1:0] hl, ll, ph_d;
   logic ph_load, ph_en, ph_zero, pc_load, pc_en, pc_zero;
   logic dout_n, pos_n, neg_n, busy_n, done_n;
   function automatic logic [CNT_W-1:0] m1(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : v - CNT_W'(1);
   endfunction
   edge_dcount #(.W(CNT_W)) u_phase (
      .Clk(Clk), .Rst(Rst), .load(ph_load), .en(ph_en), .d(ph_d), .zero(ph_zero)
   );
   edge_dcount #(.W(NUM_W)) u_pulses (
      .Clk(Clk), .Rst(Rst), .load(pc_load), .en(pc_en), .d(Num_pulses), .zero(pc_zero)
   );
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         state    <= IDLE;
         hl       <= '0;
         ll       <= '0;
         Dout     <= 1'b0;
         Pos_mark <= 1'b0;
         Neg_mark <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
      end else begin
         state    <= state_n;
         hl       <= pc_load ? High_len : hl;
         ll       <= pc_load ? Low_len : ll;
         Dout     <= dout_n;
         Pos_mark <= pos_n;
         Neg_mark <= neg_n;
         Busy     <= busy_n;
         Done     <= done_n;
      end
   always_comb begin
      state_n = state;
      ph_load = 1'b0;
      ph_en   = 1'b0;
      pc_load = 1'b0;
      pc_en   = 1'b0;
      ph_d    = (state == IDLE) ? m1(High_len) : (state == HIGH) ? m1(ll) : m1(hl);
      case (state)
         IDLE: if (Start && Num_pulses != '0) begin
            state_n = HIGH;
            ph_load = 1'b1;
            pc_load = 1'b1;
         end
         HIGH: if (Abort) state_n = IDLE;
         else if (ph_zero) begin
            state_n = LOW;
            ph_load = 1'b1;
            pc_en   = 1'b1;
         end else ph_en = 1'b1;
         LOW: if (Abort) state_n = IDLE;
         else if (ph_zero) begin
            state_n = pc_zero ? IDLE : HIGH;
            ph_load = !pc_zero;
         end else ph_en = 1'b1;
         default: state_n = IDLE;
      endcase
   end
   // Dout is high exactly in HIGH, so marks fall out of state transitions
   always_comb begin
      dout_n = (state_n == HIGH);
      pos_n  = (state_n == HIGH) && (state != HIGH);
      neg_n  = (state == HIGH) && (state_n != HIGH);
      busy_n = (state_n != IDLE);
      done_n = (state == IDLE && Start && Num_pulses == '0) ||
               (state == LOW && !Abort && ph_zero && pc_zero);
   end
endmodule

// File: tb/tb_edge_pattern_gen.sv
// tb_edge_pattern_gen: scoreboard bench with a waveform-level reference model.
module tb_edge_pattern_gen;
   logic Clk = 1'b0, Rst = 1'b1, Start = 1'b0, Abort = 1'b0;
   logic [7:0] High_len = '0, Low_len = '0, Num_pulses = '0;
   logic Dout, Pos_mark, Neg_mark, Busy, Done;
   int checks = 0, errors = 0;
   logic [4:0] tq[$];
   logic [4:0] sb[$];
   logic [4:0] last_exp = '0;
   logic prev_dout = 1'b0;

   edge_pattern_gen dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .High_len(High_len), .Low_len(Low_len),
      .Num_pulses(Num_pulses), .Abort(Abort), .Dout(Dout), .Pos_mark(Pos_mark),
      .Neg_mark(Neg_mark), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   // Model: an accepted command expands into its whole per-cycle waveform {dout,pos,neg,busy,done}
   initial forever begin
      logic [4:0] e;
      int hp, lp;
      @(posedge Clk);
      if (Rst) begin
         tq.delete();
         e = '0;
      end else if (tq.size() == 0) begin
         if (Start && Num_pulses == 0) e = 5'b00001;
         else if (Start) begin
            hp = (High_len == 0) ? 1 : int'(High_len);
            lp = (Low_len == 0) ? 1 : int'(Low_len);
            for (int p = 0; p < int'(Num_pulses); p++) begin
               for (int i = 0; i < hp; i++) tq.push_back({1'b1, i == 0, 1'b0, 1'b1, 1'b0});
               for (int i = 0; i < lp; i++) tq.push_back({1'b0, 1'b0, i == 0, 1'b1, 1'b0});
            end
            tq.push_back(5'b00001);
            e = tq.pop_front();
         end else e = '0;
      end else if (Abort) begin
         e = {2'b00, last_exp[4], 2'b00};
         tq.delete();
      end else e = tq.pop_front();
      last_exp = e;
      sb.push_back(e);
   end

   initial forever begin
      logic [4:0] e, act;
      @(negedge Clk);
      act = {Dout, Pos_mark, Neg_mark, Busy, Done};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL sb_empty t=%0t act=%b", $time, act);
      end else begin
         e = sb.pop_front();
         if (act !== e) begin
            errors++;
            $display("FAIL outputs t=%0t act={dout,pos,neg,busy,done}=%b exp=%b", $time, act, e);
         end
      end
      if (!Rst) begin
         checks++;
         if (Pos_mark !== (Dout & ~prev_dout) || Neg_mark !== (~Dout & prev_dout)) begin
            errors++;
            $display("FAIL edge_marks t=%0t pos=%b neg=%b dout=%b prev=%b", $time, Pos_mark, Neg_mark, Dout, prev_dout);
         end
      end
      prev_dout = Dout;
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic cmd(input int h, input int l, input int n);
      step();
      High_len = 8'(h);
      Low_len = 8'(l);
      Num_pulses = 8'(n);
      Start = 1'b1;
      step();
      Start = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 3000 && (Busy || Done); i++) step();
      if (i == 3000) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout busy=%b", Busy);
      end
      repeat (2) step();
   endtask

   task automatic direct(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%b exp=%b", name, act, exp);
      end
   endtask

   initial begin
      #1;
      direct("reset_state", {Dout, Pos_mark, Neg_mark, Busy, Done}, 5'b0);
      @(negedge Clk);
      #1 Rst = 1'b0;
      repeat (2) step();
      cmd(2, 3, 2);
      wait_idle();
      cmd(0, 0, 3);
      wait_idle();
      cmd(5, 5, 0);
      wait_idle();
      cmd(4, 2, 1);
      Abort = 1'b1;
      step();
      Abort = 1'b0;
      Start = 1'b1;
      step();
      Start = 1'b0;
      wait_idle();
      step();
      High_len = 8'd1;
      Low_len = 8'd1;
      Num_pulses = 8'd1;
      Start = 1'b1;
      repeat (9) begin
         step();
         High_len = 8'($urandom_range(0, 3));
         Low_len = 8'($urandom_range(0, 3));
         Num_pulses = 8'($urandom_range(1, 2));
      end
      Start = 1'b0;
      wait_idle();
      cmd(2, 6, 1);
      repeat (3) step();
      @(negedge Clk);
      #1 Rst = 1'b1;
      #1 direct("async_reset", {Dout, Pos_mark, Neg_mark, Busy, Done}, 5'b0);
      @(negedge Clk);
      #1 Rst = 1'b0;
      cmd(3, 2, 2);
      wait_idle();
      repeat (40) begin
         cmd($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
         repeat ($urandom_range(0, 14)) begin
            step();
            Abort = ($urandom_range(0, 15) == 0);
            Start = ($urandom_range(0, 7) == 0);
            High_len = 8'($urandom_range(0, 4));
            Low_len = 8'($urandom_range(0, 4));
            Num_pulses = 8'($urandom_range(0, 3));
         end
         step();
         Abort = 1'b0;
         Start = 1'b0;
      end
      wait_idle();
      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
